vm2002_change_dispenser: RTL and testbench

Change-return engine for the vm2002 vending machine. It accepts a change amount in cents from the vending controller, which is the `balance` value computed at dispense. It pays that amount out one coin per dispense slot using the same 2-bit coin encoding the controller uses on its `coins` input. It keeps per-denomination coin-tube inventories, refilled through a supplier-side port, and reports any amount it could not pay.

---
 rtl/vm2002_pkg.sv | 39 +++
 rtl/vm2002_coin_tube.sv | 55 +++++
 rtl/vm2002_change_dispenser.sv | 192 +++++++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm2002_pkg.sv
// Shared vm2002 types: coin encoding, coin values and change-dispenser states.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package vm2002_pkg;

  // 2-bit coin encoding. The vending controller's coin input uses the same encoding.
  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_e;

  typedef coin_e coins_t;

  localparam logic [15:0] NICKEL_CENTS  = 16'd5;
  localparam logic [15:0] DIME_CENTS    = 16'd10;
  localparam logic [15:0] QUARTER_CENTS = 16'd25;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    GAP      = 2'b10
  } chg_state_e;

  // Value in cents of one coin. NONE is worth nothing.
  function automatic logic [15:0] coin_cents(input coin_e c);
    logic [15:0] v;
    v = 16'd0;
    case (c)
      NICKEL:  v = NICKEL_CENTS;
      DIME:    v = DIME_CENTS;
      QUARTER: v = QUARTER_CENTS;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin tube. Holds a saturating coin count with refill add and dispense decrement.
// Latency: count updates on the edge that applies a refill or decrement. refill_err is combinational.
// Backpressure: none. A refill that overflows saturates at TUBE_DEPTH and flags refill_err.
//
// Ports: clk, hrst (sync, active-high), refill_en/refill_count (add coins),
//        dec_en (remove one coin), cnt (current count), empty (cnt == 0),
//        refill_err (this cycle's refill would exceed TUBE_DEPTH).
module vm2002_coin_tube #(
  parameter int unsigned TUBE_DEPTH = 32,
  parameter int unsigned INIT_FILL  = 0
) (
  input  logic       clk,
  input  logic       hrst,
  input  logic       refill_en,
  input  logic [5:0] refill_count,
  input  logic       dec_en,
  output logic [5:0] cnt,
  output logic       empty,
  output logic       refill_err
);

  logic [5:0] cnt_q, cnt_d;
  logic [6:0] sum;

  // The sum is 7 bits wide so that a 63 + 63 refill cannot wrap before the saturation check.
  // A refill and a decrement are never requested together, because refills happen only in
  // IDLE and decrements only in DISPENSE. The refill wins if both ever arrive together.
  always_comb begin
    sum        = {1'b0, cnt_q} + {1'b0, refill_count};
    cnt_d      = cnt_q;
    refill_err = 1'b0;
    if (refill_en) begin
      if (sum > 7'(TUBE_DEPTH)) begin
        cnt_d      = 6'(TUBE_DEPTH);
        refill_err = 1'b1;
      end else begin
        cnt_d = sum[5:0];
      end
    end else if (dec_en && (cnt_q != 6'd0)) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hrst) begin
      cnt_q <= 6'(INIT_FILL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign empty = (cnt_q == 6'd0);

endmodule

// File: rtl/vm2002_change_dispenser.sv
// vm2002 change-return engine. Pays out an amount greedily, one coin per slot, from three tubes.
// Latency: first coin or done one cycle after the request is accepted. Coins are GAP_CYCLES+1 cycles apart.
// Backpressure: ready is high only in IDLE. Requests and refills outside IDLE are ignored.
//
// Ports: clk, hrst (sync, active-high); change_req/change_amt (payout request);
//        ready (IDLE); coin_valid/coin_out (coin ejected); done/short/rem_out
//        (payout result); refill_valid/refill_coin/refill_count/refill_err
//        (tube refill); nickel_cnt/dime_cnt/quarter_cnt (tube counts).
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int unsigned TUBE_DEPTH = 32,
  parameter int unsigned INIT_FILL  = 0,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        hrst,
  input  logic        change_req,
  input  logic [15:0] change_amt,
  output logic        ready,
  output logic        coin_valid,
  output logic [1:0]  coin_out,
  output logic        done,
  output logic        short,
  output logic [15:0] rem_out,
  input  logic        refill_valid,
  input  logic [1:0]  refill_coin,
  input  logic [5:0]  refill_count,
  output logic        refill_err,
  output logic [5:0]  nickel_cnt,
  output logic [5:0]  dime_cnt,
  output logic [5:0]  quarter_cnt
);

  chg_state_e  state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        coin_valid_q, coin_valid_d;
  coin_e       coin_out_q, coin_out_d;
  logic        done_q, done_d;
  logic        short_q, short_d;
  logic [15:0] rem_out_q, rem_out_d;
  logic        refill_err_q, refill_err_d;

  coin_e       sel;
  coin_e       refill_sel;
  logic        refill_go;
  logic        n_refill, d_refill, q_refill;
  logic        n_dec, d_dec, q_dec;
  logic        n_empty, d_empty, q_empty;
  logic        n_err, d_err, q_err;

  assign ready      = (state_q == IDLE);
  assign refill_sel = coin_e'(refill_coin);
  assign refill_go  = ready && refill_valid;
  assign n_refill   = refill_go && (refill_sel == NICKEL);
  assign d_refill   = refill_go && (refill_sel == DIME);
  assign q_refill   = refill_go && (refill_sel == QUARTER);

  vm2002_coin_tube #(.TUBE_DEPTH(TUBE_DEPTH), .INIT_FILL(INIT_FILL)) u_nickel_tube (
    .clk          (clk),
    .hrst         (hrst),
    .refill_en    (n_refill),
    .refill_count (refill_count),
    .dec_en       (n_dec),
    .cnt          (nickel_cnt),
    .empty        (n_empty),
    .refill_err   (n_err)
  );

  vm2002_coin_tube #(.TUBE_DEPTH(TUBE_DEPTH), .INIT_FILL(INIT_FILL)) u_dime_tube (
    .clk          (clk),
    .hrst         (hrst),
    .refill_en    (d_refill),
    .refill_count (refill_count),
    .dec_en       (d_dec),
    .cnt          (dime_cnt),
    .empty        (d_empty),
    .refill_err   (d_err)
  );

  vm2002_coin_tube #(.TUBE_DEPTH(TUBE_DEPTH), .INIT_FILL(INIT_FILL)) u_quarter_tube (
    .clk          (clk),
    .hrst         (hrst),
    .refill_en    (q_refill),
    .refill_count (refill_count),
    .dec_en       (q_dec),
    .cnt          (quarter_cnt),
    .empty        (q_empty),
    .refill_err   (q_err)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    coin_valid_d = 1'b0;
    coin_out_d   = NONE;
    done_d       = 1'b0;
    short_d      = short_q;
    rem_out_d    = rem_out_q;
    // Only one tube can be refilled per cycle, so at most one of these is set.
    refill_err_d = n_err | d_err | q_err;
    sel          = NONE;
    n_dec        = 1'b0;
    d_dec        = 1'b0;
    q_dec        = 1'b0;

    case (state_q)
      IDLE: begin
        if (change_req) begin
          rem_d   = change_amt;
          state_d = DISPENSE;
        end
      end

      DISPENSE: begin
        // Fixed greedy priority: largest coin that fits and is in stock.
        if ((rem_q >= QUARTER_CENTS) && !q_empty) begin
          sel = QUARTER;
        end else if ((rem_q >= DIME_CENTS) && !d_empty) begin
          sel = DIME;
        end else if ((rem_q >= NICKEL_CENTS) && !n_empty) begin
          sel = NICKEL;
        end

        if (sel != NONE) begin
          n_dec        = (sel == NICKEL);
          d_dec        = (sel == DIME);
          q_dec        = (sel == QUARTER);
          rem_d        = rem_q - coin_cents(sel);
          coin_valid_d = 1'b1;
          coin_out_d   = sel;
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYCLES);
          end
        end else begin
          done_d    = 1'b1;
          short_d   = (rem_q != 16'd0);
          rem_out_d = rem_q;
          state_d   = IDLE;
        end
      end

      GAP: begin
        // A GAP of N cycles means N cycles in this state. The counter leaves when it reads 1.
        if (gap_q <= 4'd1) begin
          state_d = DISPENSE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (hrst) begin
      state_q      <= IDLE;
      rem_q        <= 16'd0;
      gap_q        <= 4'd0;
      coin_valid_q <= 1'b0;
      coin_out_q   <= NONE;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      rem_out_q    <= 16'd0;
      refill_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      coin_valid_q <= coin_valid_d;
      coin_out_q   <= coin_out_d;
      done_q       <= done_d;
      short_q      <= short_d;
      rem_out_q    <= rem_out_d;
      refill_err_q <= refill_err_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_out   = coin_out_q;
  assign done       = done_q;
  assign short      = short_q;
  assign rem_out    = rem_out_q;
  assign refill_err = refill_err_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
module tb_vm2002_change_dispenser;

  logic        clk;
  logic        hrst;
  logic        change_req;
  logic [15:0] change_amt;
  logic        ready;
  logic        coin_valid;
  logic [1:0]  coin_out;
  logic        done;
  logic        short;
  logic [15:0] rem_out;
  logic        refill_valid;
  logic [1:0]  refill_coin;
  logic [5:0]  refill_count;
  logic        refill_err;
  logic [5:0]  nickel_cnt;
  logic [5:0]  dime_cnt;
  logic [5:0]  quarter_cnt;

  int n_chk;
  int n_pass;

  // Results gathered by do_payout. Cycle numbers count edges after the accepting edge.
  logic [1:0]  got_coin [16];
  int          got_cyc  [16];
  int          got_n;
  logic        got_done;
  int          done_cyc;
  logic        got_short;
  logic [15:0] got_rem;
  logic        got_ready;
  logic        got_to;
  logic        bad_coin;
  logic        last_err;

  vm2002_change_dispenser #(
    .TUBE_DEPTH (32),
    .INIT_FILL  (0),
    .GAP_CYCLES (2)
  ) dut (
    .clk          (clk),
    .hrst         (hrst),
    .change_req   (change_req),
    .change_amt   (change_amt),
    .ready        (ready),
    .coin_valid   (coin_valid),
    .coin_out     (coin_out),
    .done         (done),
    .short        (short),
    .rem_out      (rem_out),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_count (refill_count),
    .refill_err   (refill_err),
    .nickel_cnt   (nickel_cnt),
    .dime_cnt     (dime_cnt),
    .quarter_cnt  (quarter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  task automatic apply_reset();
    hrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hrst = 1'b0;
  endtask

  task automatic refill(input logic [1:0] c, input logic [5:0] n);
    refill_valid = 1'b1;
    refill_coin  = c;
    refill_count = n;
    @(posedge clk);
    #1;
    last_err     = refill_err;
    refill_valid = 1'b0;
    refill_coin  = 2'b00;
    refill_count = 6'd0;
  endtask

  // Issues a request (optionally with a refill in the same cycle) and records coins and done.
  // If abort_after > 0, it stops watching once that many coins have been seen.
  task automatic do_payout(input logic [15:0] amt, input logic [1:0] rf_coin,
                           input logic [5:0] rf_cnt, input int abort_after);
    got_n    = 0;
    got_done = 1'b0;
    got_to   = 1'b0;
    bad_coin = 1'b0;
    done_cyc = -1;
    change_amt   = amt;
    change_req   = 1'b1;
    refill_valid = (rf_coin != 2'b00);
    refill_coin  = rf_coin;
    refill_count = rf_cnt;
    @(posedge clk);
    #1;
    change_req   = 1'b0;
    refill_valid = 1'b0;
    refill_coin  = 2'b00;
    refill_count = 6'd0;
    for (int c = 1; c <= 300 && !got_done && !(abort_after > 0 && got_n >= abort_after); c++) begin
      @(posedge clk);
      #1;
      if (coin_valid && got_n < 16) begin
        got_coin[got_n] = coin_out;
        got_cyc[got_n]  = c;
        got_n++;
      end
      if (!coin_valid && coin_out != 2'b00) bad_coin = 1'b1;
      if (done) begin
        got_done  = 1'b1;
        done_cyc  = c;
        got_short = short;
        got_rem   = rem_out;
        got_ready = ready;
      end
    end
    got_to = !got_done && !(abort_after > 0 && got_n >= abort_after);
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", ready); else n_pass++;
    n_chk++; if (coin_valid !== 1'b0 || coin_out !== 2'b00)
      $display("FAIL rst_coin got %b/%b exp 0/00", coin_valid, coin_out); else n_pass++;
    n_chk++; if (done !== 1'b0 || short !== 1'b0 || rem_out !== 16'd0)
      $display("FAIL rst_result got done=%b short=%b rem=%0d exp 0/0/0", done, short, rem_out); else n_pass++;
    n_chk++; if (refill_err !== 1'b0) $display("FAIL rst_refill_err got %b exp 0", refill_err); else n_pass++;
    n_chk++; if ({quarter_cnt, dime_cnt, nickel_cnt} !== 18'd0)
      $display("FAIL rst_counts got %0d/%0d/%0d exp 0/0/0", quarter_cnt, dime_cnt, nickel_cnt); else n_pass++;
  endtask

  task automatic test_greedy_65();
    apply_reset();
    refill(2'b11, 6'd10);
    n_chk++; if (last_err !== 1'b0) $display("FAIL g65_refill_err got %b exp 0", last_err); else n_pass++;
    refill(2'b10, 6'd10);
    refill(2'b01, 6'd10);
    n_chk++; if ({quarter_cnt, dime_cnt, nickel_cnt} !== {6'd10, 6'd10, 6'd10})
      $display("FAIL g65_fill got %0d/%0d/%0d exp 10/10/10", quarter_cnt, dime_cnt, nickel_cnt); else n_pass++;
    do_payout(16'd65, 2'b00, 6'd0, 0);
    n_chk++; if (got_to !== 1'b0) $display("FAIL g65_timeout got timeout exp done"); else n_pass++;
    n_chk++; if (got_n !== 4) $display("FAIL g65_ncoins got %0d exp 4", got_n); else n_pass++;
    n_chk++; if ({got_coin[0], got_coin[1], got_coin[2], got_coin[3]} !== 8'b11_11_10_01)
      $display("FAIL g65_seq got %b%b%b%b exp 11111001", got_coin[0], got_coin[1], got_coin[2], got_coin[3]);
    else n_pass++;
    n_chk++; if (got_cyc[0] !== 1 || got_cyc[1] !== 4 || got_cyc[2] !== 7 || got_cyc[3] !== 10)
      $display("FAIL g65_spacing got %0d,%0d,%0d,%0d exp 1,4,7,10", got_cyc[0], got_cyc[1], got_cyc[2], got_cyc[3]);
    else n_pass++;
    n_chk++; if (done_cyc !== 13) $display("FAIL g65_done_cyc got %0d exp 13", done_cyc); else n_pass++;
    n_chk++; if (got_short !== 1'b0 || got_rem !== 16'd0 || got_ready !== 1'b1)
      $display("FAIL g65_result got short=%b rem=%0d ready=%b exp 0/0/1", got_short, got_rem, got_ready); else n_pass++;
    n_chk++; if ({quarter_cnt, dime_cnt, nickel_cnt} !== {6'd8, 6'd9, 6'd9})
      $display("FAIL g65_counts got %0d/%0d/%0d exp 8/9/9", quarter_cnt, dime_cnt, nickel_cnt); else n_pass++;
    n_chk++; if (bad_coin !== 1'b0) $display("FAIL g65_idle_coin got nonzero coin_out exp 00"); else n_pass++;
  endtask

  task automatic test_dimes_30();
    apply_reset();
    refill(2'b10, 6'd5);
    refill(2'b01, 6'd5);
    do_payout(16'd30, 2'b00, 6'd0, 0);
    n_chk++; if (got_n !== 3 || {got_coin[0], got_coin[1], got_coin[2]} !== 6'b10_10_10)
      $display("FAIL d30_seq got n=%0d %b%b%b exp 3 101010", got_n, got_coin[0], got_coin[1], got_coin[2]);
    else n_pass++;
    n_chk++; if (got_done !== 1'b1 || done_cyc !== 10 || got_short !== 1'b0)
      $display("FAIL d30_done got done=%b cyc=%0d short=%b exp 1/10/0", got_done, done_cyc, got_short); else n_pass++;
    n_chk++; if ({quarter_cnt, dime_cnt, nickel_cnt} !== {6'd0, 6'd2, 6'd5})
      $display("FAIL d30_counts got %0d/%0d/%0d exp 0/2/5", quarter_cnt, dime_cnt, nickel_cnt); else n_pass++;
  endtask

  task automatic test_short_40();
    apply_reset();
    refill(2'b11, 6'd1);
    refill(2'b01, 6'd1);
    do_payout(16'd40, 2'b00, 6'd0, 0);
    n_chk++; if (got_n !== 2 || {got_coin[0], got_coin[1]} !== 4'b11_01)
      $display("FAIL s40_seq got n=%0d %b%b exp 2 1101", got_n, got_coin[0], got_coin[1]); else n_pass++;
    n_chk++; if (got_done !== 1'b1 || done_cyc !== 7)
      $display("FAIL s40_done got done=%b cyc=%0d exp 1/7", got_done, done_cyc); else n_pass++;
    n_chk++; if (got_short !== 1'b1 || got_rem !== 16'd10)
      $display("FAIL s40_short got short=%b rem=%0d exp 1/10", got_short, got_rem); else n_pass++;
  endtask

  // Relies on the previous test leaving short=1 and rem_out=10 so the reset clear is visible.
  task automatic test_hrst_abort();
    refill(2'b11, 6'd10);
    refill(2'b10, 6'd10);
    refill(2'b01, 6'd10);
    do_payout(16'd65, 2'b00, 6'd0, 2);
    n_chk++; if (got_n !== 2 || got_done !== 1'b0)
      $display("FAIL abort_pre got coins=%0d done=%b exp 2/0", got_n, got_done); else n_pass++;
    hrst = 1'b1;
    @(posedge clk);
    #1;
    hrst = 1'b0;
    n_chk++; if (ready !== 1'b1 || done !== 1'b0 || coin_valid !== 1'b0 || coin_out !== 2'b00)
      $display("FAIL abort_state got ready=%b done=%b cv=%b co=%b exp 1/0/0/00", ready, done, coin_valid, coin_out);
    else n_pass++;
    n_chk++; if (short !== 1'b0 || rem_out !== 16'd0 || refill_err !== 1'b0)
      $display("FAIL abort_outs got short=%b rem=%0d err=%b exp 0/0/0", short, rem_out, refill_err); else n_pass++;
    n_chk++; if ({quarter_cnt, dime_cnt, nickel_cnt} !== 18'd0)
      $display("FAIL abort_counts got %0d/%0d/%0d exp 0/0/0", quarter_cnt, dime_cnt, nickel_cnt); else n_pass++;
    got_done = 1'b0;
    got_n    = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) got_done = 1'b1;
      if (coin_valid) got_n++;
    end
    n_chk++; if (got_done !== 1'b0 || got_n !== 0)
      $display("FAIL abort_quiet got done=%b coins=%0d exp 0/0", got_done, got_n); else n_pass++;
  endtask

  task automatic test_odd_and_zero();
    apply_reset();
    refill(2'b11, 6'd32);
    refill(2'b10, 6'd32);
    refill(2'b01, 6'd32);
    do_payout(16'd7, 2'b00, 6'd0, 0);
    n_chk++; if (got_n !== 1 || got_coin[0] !== 2'b01 || got_cyc[0] !== 1)
      $display("FAIL odd7_coin got n=%0d coin=%b cyc=%0d exp 1/01/1", got_n, got_coin[0], got_cyc[0]); else n_pass++;
    n_chk++; if (got_done !== 1'b1 || done_cyc !== 4 || got_short !== 1'b1 || got_rem !== 16'd2)
      $display("FAIL odd7_done got cyc=%0d short=%b rem=%0d exp 4/1/2", done_cyc, got_short, got_rem); else n_pass++;
    n_chk++; if (nickel_cnt !== 6'd31) $display("FAIL odd7_nickels got %0d exp 31", nickel_cnt); else n_pass++;
    do_payout(16'd0, 2'b00, 6'd0, 0);
    n_chk++; if (got_n !== 0 || got_done !== 1'b1 || done_cyc !== 1)
      $display("FAIL zero_done got coins=%0d done=%b cyc=%0d exp 0/1/1", got_n, got_done, done_cyc); else n_pass++;
    n_chk++; if (got_short !== 1'b0 || got_rem !== 16'd0 || got_ready !== 1'b1)
      $display("FAIL zero_result got short=%b rem=%0d ready=%b exp 0/0/1", got_short, got_rem, got_ready); else n_pass++;
  endtask

  task automatic test_refill();
    logic seen_done;
    logic seen_err;
    apply_reset();
    refill(2'b10, 6'd30);
    n_chk++; if (last_err !== 1'b0 || dime_cnt !== 6'd30)
      $display("FAIL rf30 got err=%b cnt=%0d exp 0/30", last_err, dime_cnt); else n_pass++;
    refill(2'b10, 6'd5);
    n_chk++; if (last_err !== 1'b1 || dime_cnt !== 6'd32)
      $display("FAIL rf_sat got err=%b cnt=%0d exp 1/32", last_err, dime_cnt); else n_pass++;
    @(posedge clk);
    #1;
    n_chk++; if (refill_err !== 1'b0) $display("FAIL rf_pulse got %b exp 0", refill_err); else n_pass++;
    refill(2'b00, 6'd5);
    n_chk++; if (last_err !== 1'b0 || {quarter_cnt, dime_cnt, nickel_cnt} !== {6'd0, 6'd32, 6'd0})
      $display("FAIL rf_noop got err=%b %0d/%0d/%0d exp 0 0/32/0", last_err, quarter_cnt, dime_cnt, nickel_cnt);
    else n_pass++;

    // Refill while in GAP must be ignored.
    apply_reset();
    refill(2'b11, 6'd2);
    change_amt = 16'd50;
    change_req = 1'b1;
    @(posedge clk);
    #1;
    change_req = 1'b0;
    @(posedge clk);
    #1;
    n_chk++; if (coin_valid !== 1'b1 || coin_out !== 2'b11 || ready !== 1'b0)
      $display("FAIL gap_first got cv=%b co=%b ready=%b exp 1/11/0", coin_valid, coin_out, ready); else n_pass++;
    refill(2'b11, 6'd5);
    n_chk++; if (quarter_cnt !== 6'd1 || last_err !== 1'b0)
      $display("FAIL gap_refill got cnt=%0d err=%b exp 1/0", quarter_cnt, last_err); else n_pass++;
    seen_done = 1'b0;
    seen_err  = 1'b0;
    for (int c = 0; c < 50 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      if (refill_err) seen_err = 1'b1;
      if (done) begin
        seen_done = 1'b1;
        got_short = short;
      end
    end
    n_chk++; if (seen_done !== 1'b1 || got_short !== 1'b0 || quarter_cnt !== 6'd0 || seen_err !== 1'b0)
      $display("FAIL gap_end got done=%b short=%b q=%0d err=%b exp 1/0/0/0", seen_done, got_short, quarter_cnt, seen_err);
    else n_pass++;

    // Refill and request in the same IDLE cycle; dispense must see the new dime.
    apply_reset();
    do_payout(16'd10, 2'b10, 6'd1, 0);
    n_chk++; if (got_n !== 1 || got_coin[0] !== 2'b10 || got_cyc[0] !== 1)
      $display("FAIL same_cyc_coin got n=%0d coin=%b cyc=%0d exp 1/10/1", got_n, got_coin[0], got_cyc[0]); else n_pass++;
    n_chk++; if (got_done !== 1'b1 || done_cyc !== 4 || got_short !== 1'b0 || dime_cnt !== 6'd0)
      $display("FAIL same_cyc_done got cyc=%0d short=%b d=%0d exp 4/0/0", done_cyc, got_short, dime_cnt); else n_pass++;
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    hrst         = 1'b1;
    change_req   = 1'b0;
    change_amt   = 16'd0;
    refill_valid = 1'b0;
    refill_coin  = 2'b00;
    refill_count = 6'd0;
    last_err     = 1'b0;
    got_short    = 1'b0;

    test_reset();
    test_greedy_65();
    test_dimes_30();
    test_short_40();
    test_hrst_abort();
    test_odd_and_zero();
    test_refill();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
